// File: rtl/tinychip_pkg.sv
// Shared constants and state encoding for the tinychip instruction-memory loader.
package tinychip_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LO,
    ST_HI,
    ST_WRITE,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } loader_state_t;

endpackage

// File: rtl/xor_accumulator.sv
// Running XOR of accepted bytes; used as the program checksum when
// IMEM_LOADER_CHECKSUM_EN is defined.
module xor_accumulator (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] data,
  output logic [7:0] sum
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum <= 8'h00;
    end else if (clear) begin
      sum <= 8'h00;
    end else if (enable) begin
      sum <= sum ^ data;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a host byte stream into instruction memory as 9-bit words while holding the core.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
  import tinychip_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W:0]    prog_len,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               byte_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               core_hold,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE     = 1;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam loader_state_t END_ST = ST_CHK;
`else
  localparam loader_state_t END_ST = ST_DONE;
`endif

  loader_state_t   state, next_state;
  logic [ADDR_W:0] count, len_reg;
  logic [7:0]      lo_byte;
  logic            hi_bit;
  logic            load_start, take_lo, take_hi, advance, last_instr;

  assign last_instr = (count == len_reg - ONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] sum;

  xor_accumulator u_csum (
    .clk    (clk),
    .reset  (reset),
    .clear  (load_start),
    .enable (take_lo | take_hi),
    .data   (byte_data),
    .sum    (sum)
  );
`endif

  always_comb begin
    next_state = state;
    byte_ready = 1'b0;
    load_start = 1'b0;
    take_lo    = 1'b0;
    take_hi    = 1'b0;
    advance    = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          if (prog_len > MAX_LEN) begin
            next_state = ST_ERR;
          end else begin
            load_start = 1'b1;
            next_state = (prog_len == '0) ? END_ST : ST_LO;
          end
        end
      end
      ST_LO: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          take_lo    = 1'b1;
          next_state = ST_HI;
        end
      end
      ST_HI: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          // Only bit 0 of the high byte is meaningful; anything else aborts the load.
          if (byte_data[7:1] != 7'd0) begin
            next_state = ST_ERR;
          end else begin
            take_hi    = 1'b1;
            next_state = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (last_instr) begin
          next_state = END_ST;
        end else begin
          advance    = 1'b1;
          next_state = ST_LO;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHK: begin
        byte_ready = 1'b1;
        if (byte_valid) next_state = (byte_data == sum) ? ST_DONE : ST_ERR;
      end
`endif
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      len_reg <= '0;
      lo_byte <= 8'h00;
      hi_bit  <= 1'b0;
    end else begin
      if (load_start) begin
        count   <= '0;
        len_reg <= prog_len;
      end else if (advance) begin
        count <= count + ONE;
      end
      if (take_lo) lo_byte <= byte_data;
      if (take_hi) hi_bit  <= byte_data[0];
    end
  end

  assign imem_we    = (state == ST_WRITE);
  assign imem_addr  = count[ADDR_W-1:0];
  assign imem_wdata = {hi_bit, lo_byte};
  assign busy       = (state == ST_LO) || (state == ST_HI) ||
                      (state == ST_WRITE) || (state == ST_CHK);
  assign done       = (state == ST_DONE);
  assign err        = (state == ST_ERR);
  assign core_hold  = (state != ST_DONE);

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader sitting on the write side of the instruction memory: it accepts a byte stream from a host over a valid/ready handshake, packs each byte pair into a 9-bit instruction, and writes it to consecutive instruction-memory addresses starting at 0. It holds the processor core (controller, program counter) in hold while loading and releases it once the full program is written.

## Interface
- ADDR_W, 8, instruction-memory address width (matches the 8-bit PC)
- INSTR_W, 9, instruction width
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; begins a load, sampled only in IDLE, DONE, ERR
- prog_len  in  ADDR_W+1  number of instructions to load, 0..256, sampled on start
- byte_valid  in  1  host byte available
- byte_data  in  8  host byte
- byte_ready  out  1  loader accepts byte this cycle
- imem_we  out  1  instruction-memory write strobe, one cycle per instruction
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  INSTR_W  write data
- core_hold  out  1  1 = core must not fetch/execute
- busy  out  1  load in progress
- done  out  1  sticky, program fully loaded
- err  out  1  sticky, load aborted

## Operation
- Byte order per instruction: first byte = instr[7:0]; second byte bit0 = instr[8], bits[7:1] must be 0.
- Handshake: transfer when byte_valid && byte_ready; byte_data sampled that edge. byte_valid without ready is held by host; no bytes dropped.
- States: IDLE, LO, HI, WRITE, CHK (macro only), DONE, ERR.
- IDLE/DONE/ERR + start: prog_len > 256 -> ERR; prog_len == 0 -> DONE (or CHK with macro); else -> LO, addr counter := 0, err/done cleared, core_hold := 1.
- LO: byte_ready=1; on transfer latch low byte -> HI.
- HI: byte_ready=1; on transfer: bits[7:1] != 0 -> ERR (nothing written); else -> WRITE.
- WRITE: byte_ready=0, imem_we=1, imem_addr=counter, imem_wdata={hi[0],lo}; last instruction (counter == prog_len-1) -> DONE (or CHK), else counter+1, -> LO.
- DONE: done=1, core_hold=0, busy=0. ERR: err=1, core_hold=1, busy=0.
- start while busy: ignored. Bytes offered in IDLE/DONE/ERR: not accepted (byte_ready=0).
- Counter is ADDR_W+1 bits internally; imem_addr is its low ADDR_W bits; 256-instruction load ends at address 255, no wrap.

## Timing
- Reset values: byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_hold=1, busy=0, done=0, err=0, state IDLE.
- start edge -> LO next cycle, byte_ready=1 that cycle.
- Minimum 3 cycles per instruction (LO, HI, WRITE) with byte_valid held high.
- imem_we asserted exactly one cycle, registered; addr/wdata stable that cycle.
- done and core_hold=0 visible the cycle after the final WRITE (or CHK transfer).
- Reset mid-load: immediate return to reset values; already-written words remain in memory, core_hold=1.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined: after the last WRITE enter CHK, byte_ready=1, accept one byte; equal to XOR of all data bytes of this load -> DONE, else -> ERR. prog_len == 0 expects checksum 8'h00.
- Undefined: no CHK state, last WRITE -> DONE directly.

## Structure
- Shared package tinychip_pkg: INSTR_W, ADDR_W constants, loader_state_t enum.
- Sub-module xor_accumulator (clear, enable, byte in, 8-bit sum out), instantiated only under IMEM_LOADER_CHECKSUM_EN; core FSM is a single module.

## Test plan
- Reset, start, prog_len=2, bytes 8'h34,8'h01,8'hFF,8'h00 -> writes addr0=9'h134, addr1=9'h0FF, done=1, core_hold=0, 6 cycles from first accept.
- HI byte 8'h02 on first instruction -> err=1, core_hold=1, imem_we never asserted; new start prog_len=1 recovers and loads.
- byte_valid toggled 1/0 each cycle, prog_len=3 -> all 3 words correct, no byte skipped or duplicated.
- prog_len=256 -> last write at addr 8'hFF, done=1; prog_len=257 -> err=1 next cycle, no write.
- reset deasserted then asserted low mid-HI -> outputs at reset values, core_hold=1, restart loads correctly.
- With macro: prog_len=1, bytes 8'h0A,8'h01, checksum 8'h0B -> done; checksum 8'h0C -> err.
